// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO with registered top-of-stack, replace-top and sticky error flags.
// Optional feature: define LIFO_STACK_PEEK_EN to add a combinational peek port into the stack.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             err_clear,
`ifdef LIFO_STACK_PEEK_EN
  input  logic [CNT_W-1:0] peek_idx,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] top_addr;
  logic [ADDR_W-1:0] below_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  count_nxt;
  logic [WIDTH-1:0]  top_nxt;
  logic              wr_en;
  logic              ovf_set;
  logic              unf_set;

  assign top_addr   = ADDR_W'(count - CNT_W'(1));
  assign below_addr = ADDR_W'(count - CNT_W'(2));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    count_nxt = count;
    top_nxt   = top_data;
    wr_en     = 1'b0;
    wr_addr   = count[ADDR_W-1:0];
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (push && pop) begin
      wr_en   = 1'b1;
      top_nxt = push_data;
      if (empty) begin
        // Nothing to replace: the push goes through alone and the pop is flagged.
        count_nxt = CNT_W'(1);
        unf_set   = 1'b1;
      end else begin
        wr_addr = top_addr;
      end
    end else if (push) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en     = 1'b1;
        count_nxt = count + CNT_W'(1);
        top_nxt   = push_data;
      end
    end else if (pop) begin
      if (empty) begin
        unf_set = 1'b1;
      end else if (count == CNT_W'(1)) begin
        count_nxt = '0;
        top_nxt   = '0;
      end else begin
        count_nxt = count - CNT_W'(1);
        top_nxt   = mem[below_addr];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      top_data  <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      top_data  <= top_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CNT_W'(DEPTH));
      overflow  <= ovf_set | (overflow & ~err_clear);
      underflow <= unf_set | (underflow & ~err_clear);
    end
  end

  // NOTE: storage is deliberately not reset; entries at or above count are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= push_data;
  end

`ifdef LIFO_STACK_PEEK_EN
  logic [ADDR_W-1:0] peek_addr;
  assign peek_addr = ADDR_W'(count - CNT_W'(1) - peek_idx);
  assign peek_data = (peek_idx < count) ? mem[peek_addr] : '0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus randomized traffic against a queue model.
// Peek checks are included when LIFO_STACK_PEEK_EN is defined.
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             err_clear;
  logic [WIDTH-1:0] top_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef LIFO_STACK_PEEK_EN
  logic [CNT_W-1:0] peek_idx = '0;
  logic [WIDTH-1:0] peek_data;
`endif

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .err_clear (err_clear),
`ifdef LIFO_STACK_PEEK_EN
    .peek_idx  (peek_idx),
    .peek_data (peek_data),
`endif
    .top_data  (top_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stack as a queue whose back is the top.
  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf;
  bit               m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_top();
    return (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
  endfunction

  task automatic model_step(input bit p, input bit o, input logic [WIDTH-1:0] d,
                            input bit clr, input bit rst);
    bit ev_ovf = 0;
    bit ev_unf = 0;
    if (rst) begin
      model_q.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    if (p && o) begin
      if (model_q.size() > 0) model_q[model_q.size()-1] = d;
      else begin
        model_q.push_back(d);
        ev_unf = 1;
      end
    end else if (p) begin
      if (model_q.size() == DEPTH) ev_ovf = 1;
      else model_q.push_back(d);
    end else if (o) begin
      if (model_q.size() == 0) ev_unf = 1;
      else void'(model_q.pop_back());
    end
    m_ovf = ev_ovf | (m_ovf & ~clr);
    m_unf = ev_unf | (m_unf & ~clr);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},     32'(count),     32'(model_q.size()));
    check({tag, ".top"},       32'(top_data),  32'(model_top()));
    check({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
    check({tag, ".full"},      32'(full),      32'(model_q.size() == DEPTH));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`ifdef LIFO_STACK_PEEK_EN
    for (int i = 0; i <= DEPTH; i++) begin
      peek_idx = CNT_W'(i);
      #1;
      check({tag, ".peek"}, 32'(peek_data),
            32'((i < model_q.size()) ? model_q[model_q.size()-1-i] : '0));
    end
`endif
  endtask

  task automatic cycle(input string tag, input bit p, input bit o, input logic [WIDTH-1:0] d,
                       input bit clr, input bit rst);
    reset     = rst;
    push      = p;
    pop       = o;
    push_data = d;
    err_clear = clr;
    @(posedge clk);
    #1;
    model_step(p, o, d, clr, rst);
    reset     = 0;
    push      = 0;
    pop       = 0;
    err_clear = 0;
    check_state(tag);
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; push_data = '0; err_clear = 0;
    cycle("reset", 1, 0, 8'hEE, 0, 1);
    check("reset.top_lit", 32'(top_data), 32'h0);

    // Basic push/pop ordering
    cycle("push11", 1, 0, 8'h11, 0, 0);
    cycle("push22", 1, 0, 8'h22, 0, 0);
    cycle("push33", 1, 0, 8'h33, 0, 0);
    check("push3.top_lit", 32'(top_data), 32'h33);
    cycle("pop1", 0, 1, 8'h00, 0, 0);
    check("pop1.top_lit", 32'(top_data), 32'h22);
    cycle("pop2", 0, 1, 8'h00, 0, 0);
    check("pop2.top_lit", 32'(top_data), 32'h11);
    cycle("pop3", 0, 1, 8'h00, 0, 0);
    check("pop3.empty_lit", 32'(empty), 32'h1);

    // Fill to DEPTH and push once more
    for (int i = 0; i < 5; i++) cycle("fill", 1, 0, 8'(8'hA0 + i), 0, 0);
    check("ovf.top_lit", 32'(top_data), 32'hA3);
    check("ovf.flag_lit", 32'(overflow), 32'h1);
    cycle("ovf_clear", 0, 0, 8'h00, 1, 0);
    check("ovf_clear.lit", 32'(overflow), 32'h0);

    // Replace-top while full leaves count and overflow alone
    cycle("repl_full", 1, 1, 8'h7F, 0, 0);
    check("repl_full.count_lit", 32'(count), 32'(DEPTH));

    // Drain, underflow, then set-wins-over-clear with push+pop on empty
    for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 1, 8'h00, 0, 0);
    cycle("unf", 0, 1, 8'h00, 0, 0);
    check("unf.flag_lit", 32'(underflow), 32'h1);
    cycle("unf_setwins", 1, 1, 8'h5A, 1, 0);
    check("unf_setwins.top_lit", 32'(top_data), 32'h5A);
    check("unf_setwins.flag_lit", 32'(underflow), 32'h1);

    // Replace-top at count=2, then pop exposes the lower entry
    cycle("clr", 0, 1, 8'h00, 1, 0);
    cycle("p01", 1, 0, 8'h01, 0, 0);
    cycle("p02", 1, 0, 8'h02, 0, 0);
    cycle("repl", 1, 1, 8'h7F, 0, 0);
    check("repl.top_lit", 32'(top_data), 32'h7F);
    cycle("repl_pop", 0, 1, 8'h00, 0, 0);
    check("repl_pop.top_lit", 32'(top_data), 32'h01);

    // Reset overrides a concurrent push
    cycle("p10", 1, 0, 8'h10, 0, 0);
    cycle("p20", 1, 0, 8'h20, 0, 0);
    cycle("rst_push", 1, 0, 8'h30, 0, 1);
    check("rst_push.count_lit", 32'(count), 32'h0);
    cycle("p44", 1, 0, 8'h44, 0, 0);
    check("p44.top_lit", 32'(top_data), 32'h44);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            WIDTH'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised synchronous LIFO for the BeeF core, storing loop-return addresses and data-stack operands. It supports independent push and pop strobes, a same-cycle replace-top operation, an occupancy count, and a registered top-of-stack output. Sticky overflow and underflow flags report rejected operations. It is the general-width, general-depth LIFO used throughout the core.

## Interface
- WIDTH, 8, bits per entry (≥1)
- DEPTH, 64, number of entries (≥2; need not be a power of two)
- CNT_W, $clog2(DEPTH+1), derived width of count; not overridden
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- push  in  1  push request this cycle
- pop  in  1  pop request this cycle
- push_data  in  WIDTH  value written on an accepted push
- err_clear  in  1  clears overflow/underflow
- top_data  out  WIDTH  registered copy of the top entry; 0 when empty
- count  out  CNT_W  number of valid entries, 0..DEPTH
- empty  out  1  count == 0, registered
- full  out  1  count == DEPTH, registered
- overflow  out  1  sticky: a push was rejected because the stack was full
- underflow  out  1  sticky: a pop was rejected because the stack was empty

## Operation
- Storage: mem[0..DEPTH-1]. Entry i is valid for i < count; the top entry is mem[count-1]. Memory contents are not reset.
- Reset: count=0, empty=1, full=0, top_data=0, overflow=0, underflow=0. Reset overrides push, pop and err_clear in the same cycle. Asserting reset mid-sequence discards all entries.
- Idle (push=0, pop=0): no state change.
- Push only:
  - If not full: mem[count]<=push_data, count<=count+1, top_data<=push_data.
  - If full: nothing changes; overflow<=1.
- Pop only:
  - If count≥2: count<=count-1, top_data<=mem[count-2].
  - If count==1: count<=0, top_data<=0.
  - If empty: nothing changes; underflow<=1.
- Push and pop together:
  - If not empty: replace top. mem[count-1]<=push_data, top_data<=push_data, count unchanged, no error. This also applies when full.
  - If empty: the push is accepted as push-only and the pop is rejected, so underflow<=1.
- empty and full are recomputed from the next count every cycle. They are never both 1.
- err_clear: clears overflow and underflow. If a new error occurs in the same cycle, set wins.
- Count arithmetic is unsigned CNT_W bits. Count never wraps: rejected operations leave it unchanged.

## Timing
- Every output is registered. The effect of an operation sampled at edge N is visible after edge N.
- Latency is one cycle from push to the value appearing on top_data, and from pop to the new top appearing on top_data.
- Back-to-back push or pop every cycle is supported at full throughput, with no bubbles.
- There is no handshake. The caller must gate requests using full and empty; a violation is flagged but is otherwise harmless.
- top_data is valid whenever empty=0.

## Configuration
- LIFO_STACK_PEEK_EN
  - Defined: adds input peek_idx[CNT_W-1:0] and output peek_data[WIDTH-1:0].
    - peek_data is a combinational read of mem[count-1-peek_idx], where peek_idx=0 is the top.
    - peek_data=0 when peek_idx ≥ count.
    - It reflects the registered state, not the current cycle's push or pop.
  - Undefined: both ports are absent and there is no extra logic. All other behaviour is identical.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, top_data=0x33, empty=0, full=0. Then pop 3× -> top_data 0x22, 0x11, 0; count=0; empty=1; no flags set.
- With DEPTH=4, push 5× (0xA0..0xA4) -> full=1 after the 4th push, the 5th is rejected, overflow=1, top_data=0xA3. Pulse err_clear -> overflow=0.
- From empty, pop -> underflow=1, count=0. Then err_clear and push 0x5A in the same cycle as a pop -> count=1, top_data=0x5A, underflow=1 (set wins over clear).
- From count=2 (0x01, 0x02), push 0x7F with pop -> count=2, top_data=0x7F. Pop -> top_data=0x01. Repeat the replace while full -> count=DEPTH, no overflow.
- Push 0x10, 0x20, then assert reset together with push 0x30 -> count=0, empty=1, top_data=0, flags 0. The next push of 0x44 gives top_data=0x44.
- With LIFO_STACK_PEEK_EN defined: push 0x01, 0x02, 0x03 -> peek_idx 0/1/2 gives 0x03/0x02/0x01, and peek_idx=3 gives 0.
